// File: rtl/cv32e40s_pkg.sv
// Shared types for the CLIC interrupt arbiter: per-source configuration
// record and trigger-type encodings.
package cv32e40s_pkg;

  typedef struct packed {
    logic       ie;
    logic [7:0] level;
    logic       shv;
    logic       trig;
  } clic_arb_cfg_t;

  localparam logic CLIC_TRIG_LEVEL = 1'b0;
  localparam logic CLIC_TRIG_EDGE  = 1'b1;

endpackage

// File: rtl/cv32e40s_clic_max_tree.sv
// Combinational max-reduction over interrupt sources: highest level wins,
// ties resolved towards the highest ID.
module cv32e40s_clic_max_tree #(
  parameter int NUM_IRQ       = 32,
  parameter int CLIC_ID_WIDTH = 5
) (
  input  logic [NUM_IRQ-1:0]           req,
  input  logic [NUM_IRQ-1:0][7:0]      level,
  input  logic [NUM_IRQ-1:0]           shv,
  output logic                         win_valid,
  output logic [CLIC_ID_WIDTH-1:0]     win_id,
  output logic [7:0]                   win_level,
  output logic                         win_shv
);

  localparam int LEAVES = 1 << CLIC_ID_WIDTH;

  typedef struct packed {
    logic                     valid;
    logic [7:0]               level;
    logic [CLIC_ID_WIDTH-1:0] id;
    logic                     shv;
  } node_t;

  logic [LEAVES-1:0]      req_pad;
  logic [LEAVES-1:0]      shv_pad;
  logic [LEAVES-1:0][7:0] level_pad;
  node_t                  nodes [2*LEAVES-1];

  assign req_pad   = LEAVES'(req);
  assign shv_pad   = LEAVES'(shv);
  assign level_pad = (LEAVES*8)'(level);

  // The hi operand always covers higher IDs, so >= gives the tie to it.
  function automatic node_t pick(node_t lo, node_t hi);
    if (hi.valid && (!lo.valid || hi.level >= lo.level)) return hi;
    return lo;
  endfunction

  always_comb begin
    for (int i = 0; i < LEAVES; i++) begin
      nodes[LEAVES-1+i] = '{valid: req_pad[i], level: level_pad[i],
                            id: CLIC_ID_WIDTH'(i), shv: shv_pad[i]};
    end
    for (int k = LEAVES - 2; k >= 0; k--) begin
      nodes[k] = pick(nodes[2*k+1], nodes[2*k+2]);
    end
  end

  assign win_valid = nodes[0].valid;
  assign win_id    = nodes[0].id;
  assign win_level = nodes[0].level;
  assign win_shv   = nodes[0].shv;

endmodule

// File: rtl/cv32e40s_clic_irq_arbiter.sv
// CLIC interrupt arbiter: per-source config and pending state, registered
// highest-level request. Edge triggering is enabled by CV32E40S_CLIC_ARB_EDGE_EN.
module cv32e40s_clic_irq_arbiter
  import cv32e40s_pkg::*;
#(
  parameter int NUM_IRQ       = 32,
  parameter int CLIC_ID_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_IRQ-1:0]       irq_src_i,
  input  logic                     cfg_we_i,
  input  logic [CLIC_ID_WIDTH-1:0] cfg_id_i,
  input  logic                     cfg_ie_i,
  input  logic [7:0]               cfg_level_i,
  input  logic                     cfg_shv_i,
  input  logic                     cfg_trig_i,
  input  logic                     irq_ack_i,
  input  logic [CLIC_ID_WIDTH-1:0] irq_ack_id_i,
  output logic                     clic_irq_o,
  output logic [CLIC_ID_WIDTH-1:0] clic_irq_id_o,
  output logic [7:0]               clic_irq_level_o,
  output logic [1:0]               clic_irq_priv_o,
  output logic                     clic_irq_shv_o
);

  clic_arb_cfg_t          cfg_wdata;
  logic [NUM_IRQ-1:0]     wr_sel;
  logic [NUM_IRQ-1:0]     ie_q;
  logic [NUM_IRQ-1:0]     shv_q;
  logic [NUM_IRQ-1:0][7:0] level_q;
  logic [NUM_IRQ-1:0]     pending_q;
  logic [NUM_IRQ-1:0]     pending_d;
  logic [NUM_IRQ-1:0]     eligible;

  logic                     win_valid;
  logic [CLIC_ID_WIDTH-1:0] win_id;
  logic [7:0]               win_level;
  logic                     win_shv;

  assign cfg_wdata = '{ie: cfg_ie_i, level: cfg_level_i, shv: cfg_shv_i, trig: cfg_trig_i};

  // IDs at or above NUM_IRQ match no source, so such writes fall away here.
  always_comb begin
    for (int i = 0; i < NUM_IRQ; i++) begin
      wr_sel[i] = cfg_we_i && (cfg_id_i == CLIC_ID_WIDTH'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_q    <= '0;
      shv_q   <= '0;
      level_q <= '0;
    end else begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (wr_sel[i]) begin
          ie_q[i]    <= cfg_wdata.ie;
          level_q[i] <= cfg_wdata.level;
          shv_q[i]   <= cfg_wdata.shv;
        end
      end
    end
  end

`ifdef CV32E40S_CLIC_ARB_EDGE_EN
  logic [NUM_IRQ-1:0] src_q;
  logic [NUM_IRQ-1:0] trig_q;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;

  // A config write clears pending; a rising edge outranks a same-cycle ack.
  always_comb begin
    for (int i = 0; i < NUM_IRQ; i++) begin
      rise[i] = irq_src_i[i] & ~src_q[i];
      clr[i]  = irq_ack_i && (irq_ack_id_i == CLIC_ID_WIDTH'(i));
      if (wr_sel[i])
        pending_d[i] = 1'b0;
      else if (trig_q[i] == CLIC_TRIG_EDGE)
        pending_d[i] = rise[i] | (pending_q[i] & ~clr[i]);
      else
        pending_d[i] = irq_src_i[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q  <= '0;
      trig_q <= '0;
    end else begin
      src_q <= irq_src_i;
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (wr_sel[i]) trig_q[i] <= cfg_wdata.trig;
      end
    end
  end
`else
  logic unused_edge;

  // Level-only build: pending_q doubles as the registered source copy.
  always_comb begin
    for (int i = 0; i < NUM_IRQ; i++) begin
      pending_d[i] = wr_sel[i] ? 1'b0 : irq_src_i[i];
    end
  end

  assign unused_edge = ^{irq_ack_i, irq_ack_id_i, cfg_wdata.trig};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  always_comb begin
    for (int i = 0; i < NUM_IRQ; i++) begin
      eligible[i] = pending_q[i] & ie_q[i] & (level_q[i] != 8'd0);
    end
  end

  cv32e40s_clic_max_tree #(
    .NUM_IRQ       (NUM_IRQ),
    .CLIC_ID_WIDTH (CLIC_ID_WIDTH)
  ) u_max_tree (
    .req       (eligible),
    .level     (level_q),
    .shv       (shv_q),
    .win_valid (win_valid),
    .win_id    (win_id),
    .win_level (win_level),
    .win_shv   (win_shv)
  );

  // Output stage: id/level/shv keep the last winner while nothing is eligible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clic_irq_o       <= 1'b0;
      clic_irq_id_o    <= '0;
      clic_irq_level_o <= '0;
      clic_irq_shv_o   <= 1'b0;
    end else begin
      clic_irq_o <= win_valid;
      if (win_valid) begin
        clic_irq_id_o    <= win_id;
        clic_irq_level_o <= win_level;
        clic_irq_shv_o   <= win_shv;
      end
    end
  end

  assign clic_irq_priv_o = 2'b11;

endmodule
